// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush with bubble insertion and saturating stall/bubble counters.
module pipe_stage_skid #(
  parameter int                 CTRL_W      = 14,
  parameter int                 DATA_W      = 111,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
  parameter int                 CNT_W       = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]        occ_q, occ_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
  logic              accept, send, valid;

  assign valid  = (occ_q != EMPTY);
  assign accept = in_valid & in_ready_q;
  assign send   = valid & out_ready;

  always_comb begin
    occ_d       = occ_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // Data regs are left alone; only control is scrubbed to a bubble.
      occ_d       = EMPTY;
      main_ctrl_d = CTRL_BUBBLE;
      skid_ctrl_d = CTRL_BUBBLE;
    end else begin
      case (occ_q)
        EMPTY: if (accept) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
          occ_d       = ONE;
        end
        ONE: begin
          if (accept && send) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            occ_d       = TWO;
          end else if (send) begin
            main_ctrl_d = CTRL_BUBBLE;
            occ_d       = EMPTY;
          end
        end
        TWO: if (send) begin
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          occ_d       = ONE;
        end
        default: begin
          main_ctrl_d = CTRL_BUBBLE;
          occ_d       = EMPTY;
        end
      endcase
    end
    in_ready_d = (occ_d != TWO);
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (valid && !out_ready && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (!valid && bubble_cnt_q != CNT_MAX)             bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      occ_q        <= EMPTY;
      in_ready_q   <= 1'b1;
      main_ctrl_q  <= CTRL_BUBBLE;
      main_data_q  <= '0;
      skid_ctrl_q  <= CTRL_BUBBLE;
      skid_data_q  <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      occ_q        <= occ_d;
      in_ready_q   <= in_ready_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = valid;
  assign out_ctrl   = main_ctrl_q;
  assign out_data   = main_data_q;
  assign occupancy  = occ_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_stage_skid;
  localparam int CW = 14;
  localparam int DW = 40;
  localparam int NW = 4;
  localparam logic [CW-1:0] BUB = 14'h1F00;
  localparam int CMAX = (1 << NW) - 1;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0, cnt_clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt, bubble_cnt;

  int n_chk = 0;
  int n_fail = 0;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CTRL_BUBBLE(BUB), .CNT_W(NW)) dut (
    .clock(clock), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clock = ~clock;

  // Reference model: FIFO of at most two entries plus two saturating counters.
  typedef struct packed { logic [CW-1:0] c; logic [DW-1:0] d; } ent_t;
  ent_t mq[$];
  int   m_stall = 0;
  int   m_bubble = 0;

  always @(posedge clock or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      automatic int  n   = mq.size();
      automatic bit  acc = in_valid && (n != 2);
      automatic bit  snd = (n != 0) && out_ready;
      if (cnt_clr) begin
        m_stall = 0; m_bubble = 0;
      end else begin
        if (n != 0 && !out_ready) m_stall  = (m_stall  < CMAX) ? m_stall + 1  : CMAX;
        if (n == 0)               m_bubble = (m_bubble < CMAX) ? m_bubble + 1 : CMAX;
      end
      if (flush) mq.delete();
      else begin
        if (snd) void'(mq.pop_front());
        if (acc) mq.push_back('{c: in_ctrl, d: in_data});
      end
    end
  end

  always @(negedge clock) begin
    automatic int            n   = mq.size();
    automatic logic [CW-1:0] ec  = (n != 0) ? mq[0].c : BUB;
    automatic bit            ok  = 1'b1;
    if (out_valid !== (n != 0))         ok = 1'b0;
    if (occupancy !== 2'(n))            ok = 1'b0;
    if (in_ready !== (n != 2))          ok = 1'b0;
    if (out_ctrl !== ec)                ok = 1'b0;
    if (n != 0 && out_data !== mq[0].d) ok = 1'b0;
    if (stall_cnt !== NW'(m_stall))     ok = 1'b0;
    if (bubble_cnt !== NW'(m_bubble))   ok = 1'b0;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL model t=%0t: got v=%0b occ=%0d rdy=%0b ctrl=%h data=%h st=%0d bu=%0d; want occ=%0d ctrl=%h data=%h st=%0d bu=%0d",
               $time, out_valid, occupancy, in_ready, out_ctrl, out_data, stall_cnt, bubble_cnt,
               n, ec, (n != 0) ? mq[0].d : '0, m_stall, m_bubble);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic put(input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = 1'b1; in_ctrl = c; in_data = d;
  endtask

  localparam logic [DW-1:0] D1 = 40'hD1_0000_0001, D2 = 40'hD2_0000_0002, D3 = 40'hD3_0000_0003;
  localparam logic [DW-1:0] D4 = 40'hD4_0000_0004, D5 = 40'hD5_0000_0005, D9 = 40'hD9_0000_0009;

  initial begin
    step(2);
    chk("reset_occ", 64'(occupancy), 64'd0);
    chk("reset_rdy", 64'(in_ready), 64'd1);
    chk("reset_ctrl", 64'(out_ctrl), 64'(BUB));
    chk("reset_data", 64'(out_data), 64'd0);
    @(negedge clock); rst = 1'b0;
    step(1);

    // 1: single transfer, then bubble
    out_ready = 1'b1;
    put(14'h2A5, D1);
    step(1);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_ctrl", 64'(out_ctrl), 64'h2A5);
    chk("t1_data", 64'(out_data), 64'(D1));
    chk("t1_occ", 64'(occupancy), 64'd1);
    in_valid = 1'b0;
    step(1);
    chk("t1_bubble_valid", 64'(out_valid), 64'd0);
    chk("t1_bubble_ctrl", 64'(out_ctrl), 64'(BUB));

    // 2: fill skid under stall, then drain in order
    out_ready = 1'b0;
    put(14'h011, D1); step(1);
    put(14'h022, D2); step(1);
    chk("t2_occ2", 64'(occupancy), 64'd2);
    chk("t2_rdy0", 64'(in_ready), 64'd0);
    put(14'h033, D3); step(1);
    chk("t2_hold_data", 64'(out_data), 64'(D1));
    out_ready = 1'b1; step(1);
    chk("t2_out_d2", 64'(out_data), 64'(D2));
    chk("t2_rdy1", 64'(in_ready), 64'd1);
    step(1);
    chk("t2_out_d3", 64'(out_data), 64'(D3));
    in_valid = 1'b0; step(1);
    chk("t2_empty", 64'(occupancy), 64'd0);

    // 3: flush while full, with an incoming entry that must be dropped
    out_ready = 1'b0;
    put(14'h044, D4); step(1);
    put(14'h055, D5); step(1);
    flush = 1'b1; put(14'h099, D9); step(1);
    chk("t3_occ", 64'(occupancy), 64'd0);
    chk("t3_valid", 64'(out_valid), 64'd0);
    chk("t3_ctrl", 64'(out_ctrl), 64'(BUB));
    chk("t3_rdy", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step(2);
    chk("t3_no_d9", 64'(out_valid), 64'd0);

    // 4: stall counter counts, then saturates at 4-bit max
    out_ready = 1'b0;
    put(14'h066, D1); step(1);
    in_valid = 1'b0; cnt_clr = 1'b1; step(1);
    chk("t4_clr", 64'(stall_cnt), 64'd0);
    cnt_clr = 1'b0; step(10);
    chk("t4_stall10", 64'(stall_cnt), 64'd10);
    step(10);
    chk("t4_stall_sat", 64'(stall_cnt), 64'd15);
    out_ready = 1'b1; step(2);

    // 5: async reset while full
    out_ready = 1'b0;
    put(14'h077, D2); step(1);
    put(14'h088, D3); step(1);
    in_valid = 1'b0;
    @(negedge clock); #2 rst = 1'b1; #1;
    chk("t5_occ", 64'(occupancy), 64'd0);
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_ctrl", 64'(out_ctrl), 64'(BUB));
    chk("t5_data", 64'(out_data), 64'd0);
    chk("t5_cnt", 64'({stall_cnt, bubble_cnt}), 64'd0);
    step(1);
    @(negedge clock); #2 rst = 1'b0;
    step(1);

    // 6: random traffic against the model
    for (int i = 0; i < 5000; i++) begin
      in_valid  = ($urandom_range(99) < 60);
      in_ctrl   = 14'($urandom);
      in_data   = {8'($urandom), 32'($urandom)};
      out_ready = ($urandom_range(99) < 55);
      flush     = ($urandom_range(99) < 3);
      cnt_clr   = ($urandom_range(99) < 2);
      step(1);
    end
    in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    step(3);
    chk("t6_drained", 64'(occupancy), 64'd0);

    @(negedge clock); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
